temporal_ngram_encoder: RTL



---
 rtl/temporal_ngram_encoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/temporal_ngram_encoder.sv
// Binds each accepted spatial hypervector with rotated copies of the previous N-1 samples of the same context.
// One cycle from accept to ValidOut_SO; the output is held and no input is accepted until ReadyIn_SI.
module temporal_ngram_encoder #(
    parameter int HV_DIMENSION = 2048,
    parameter int NGRAM_SIZE   = 3,
    parameter int MODE_WIDTH   = 2,
    parameter int LABEL_WIDTH  = 5
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [MODE_WIDTH-1:0]   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [MODE_WIDTH-1:0]   ModeOut_SO,
    output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam int FILL_W     = (NGRAM_SIZE > 1) ? $clog2(NGRAM_SIZE) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NGRAM_SIZE - 1);

    typedef enum logic {
        IDLE,
        OUTPUT_STABLE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [FILL_W-1:0]       r_fill;
    logic [FILL_W-1:0]       w_eff;
    logic [FILL_W-1:0]       w_fill_nxt;
    logic [0:HV_DIMENSION-1] r_hist [HIST_DEPTH];
    logic [MODE_WIDTH-1:0]   r_ctx_mode;
    logic [LABEL_WIDTH-1:0]  r_ctx_label;
    logic [0:HV_DIMENSION-1] r_hv_out;
    logic [MODE_WIDTH-1:0]   r_mode_out;
    logic [LABEL_WIDTH-1:0]  r_label_out;
    logic [0:HV_DIMENSION-1] w_acc;
    logic [0:HV_DIMENSION-1] w_bound;
    logic                    w_ctx_match;
    logic                    w_accept;
    logic                    w_emit;

    function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    // Horner form: rho(H0 ^ rho(H1 ^ ...)) equals the sum of rho^(k+1)(H[k]).
    always_comb begin
        w_acc = '0;
        for (int k = NGRAM_SIZE - 2; k >= 0; k--) begin
            w_acc = rho(w_acc ^ r_hist[k]);
        end
        w_bound = HypervectorIn_DI ^ w_acc;
    end

    assign w_ctx_match = (ModeIn_SI == r_ctx_mode) && (LabelIn_DI == r_ctx_label);
    assign w_eff       = ((r_fill != '0) && w_ctx_match) ? r_fill : '0;
    assign w_accept    = (r_state == IDLE) && ValidIn_SI;
    assign w_emit      = w_accept && (w_eff == FILL_MAX);
    assign w_fill_nxt  = (w_eff == FILL_MAX) ? FILL_MAX : w_eff + 1'b1;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
        case (r_state)
            IDLE: begin
                ReadyOut_SO = 1'b1;
                if (w_emit) begin
                    w_state_nxt = OUTPUT_STABLE;
                end
            end
            OUTPUT_STABLE: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_fill      <= '0;
            r_ctx_mode  <= '0;
            r_ctx_label <= '0;
            r_hv_out    <= '0;
            r_mode_out  <= '0;
            r_label_out <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_hist[k] <= '0;
            end
        end else if (w_accept) begin
            if (NGRAM_SIZE > 1) begin
                r_hist[0] <= HypervectorIn_DI;
                for (int k = 1; k < HIST_DEPTH; k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
            end
            r_ctx_mode  <= ModeIn_SI;
            r_ctx_label <= LabelIn_DI;
            r_fill      <= w_fill_nxt;
            if (w_emit) begin
                r_hv_out    <= w_bound;
                r_mode_out  <= ModeIn_SI;
                r_label_out <= LabelIn_DI;
            end
        end
    end

    assign HypervectorOut_DO = r_hv_out;
    assign ModeOut_SO        = r_mode_out;
    assign LabelOut_DO       = r_label_out;

endmodule
